// File: rtl/imm_gen_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_pkg
// Description : Shared decode definitions for the immediate generator:
//               format select encoding, default widths and payload layout.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pipe_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 8;

    // Immediate format select, encoded as the decoder drives ImmSrc
    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_ILL = 3'b111
    } imm_src_e;

    // Payload held in each buffer slot, at the default widths
    typedef struct packed {
        logic [XLEN_DEF-1:0]  imm;
        logic [TAG_W_DEF-1:0] tag;
        logic                 err;
    } imm_pay_t;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Purely combinational immediate format mux; sign/zero extends
//               the selected instruction fields to XLEN and flags the
//               illegal select.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     i_instr,
    input  imm_src_e        i_src,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    logic [XLEN-1:0] w_u;
    logic [XLEN-1:0] w_sh;
    logic            w_unused;

    // Opcode bits never contribute to any immediate
    assign w_unused = &{1'b0, i_instr[6:0]};

    // U sign-extends above bit 31 and shamt gains a sixth bit on RV64
    generate
        if (XLEN == 64) begin : g_x64
            assign w_u  = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
            assign w_sh = {{(XLEN-6){1'b0}}, i_instr[25:20]};
        end else begin : g_x32
            assign w_u  = {i_instr[31:12], 12'b0};
            assign w_sh = {{(XLEN-5){1'b0}}, i_instr[24:20]};
        end
    endgenerate

    // Format mux; illegal select yields zero with the error flag raised
    always_comb begin
        o_imm = '0;
        o_err = 1'b0;
        case (i_src)
            IMM_I:   o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            IMM_S:   o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                              i_instr[11:8], 1'b0};
            IMM_J:   o_imm = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                              i_instr[30:21], 1'b0};
            IMM_U:   o_imm = w_u;
            IMM_Z:   o_imm = {{(XLEN-5){1'b0}}, i_instr[19:15]};
            IMM_SH:  o_imm = w_sh;
            default: o_err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Pipelined immediate generator with valid/ready handshake,
//               2-entry skid buffer, flush and saturating illegal-select
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [2:0]          ImmSrc,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     ImmExt,
    output logic [TAG_W-1:0]    out_tag,
    output logic                imm_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    // Slot layout matches imm_pay_t but follows this instance's widths
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } pay_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [ERRCNT_W-1:0] c_ERR_MAX = '1;

    state_e                r_state;
    pay_t                  r_out;
    pay_t                  r_skid;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [ERRCNT_W-1:0]   r_err_cnt;

    pay_t                  w_new;
    logic [XLEN-1:0]       w_imm;
    logic                  w_err;
    logic                  w_acc;
    logic                  w_con;

    imm_ext_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_instr (instr),
        .i_src   (imm_src_e'(ImmSrc)),
        .o_imm   (w_imm),
        .o_err   (w_err)
    );

    assign w_new = {w_imm, in_tag, w_err};
    assign w_acc = in_valid && r_in_ready;
    assign w_con = r_out_valid && out_ready;

    // Skid FSM: out register presents, skid register absorbs one stalled entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out       <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_out       <= w_new;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && !w_con) begin
                        r_skid     <= w_new;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (!w_acc && w_con) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end else if (w_acc && w_con) begin
                        r_out <= w_new;
                    end
                end
                ST_FULL: begin
                    if (w_con) begin
                        r_out      <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Count accepted illegal selects, flush or not, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_acc && w_err && (r_err_cnt != c_ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ImmExt    = r_out.imm;
    assign out_tag   = r_out.tag;
    assign imm_err   = r_out.err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Directed self-checking bench for imm_gen_pipe (XLEN 32 and
//               64 instances sharing one stimulus stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] ImmExt;
    logic [7:0]  out_tag;
    logic        imm_err;
    logic [7:0]  err_cnt;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] ImmExt64;
    logic [7:0]  out_tag64;
    logic        imm_err64;
    logic [7:0]  err_cnt64;

    int npass = 0;
    int ntot  = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ERRCNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .ImmExt(ImmExt),
        .out_tag(out_tag), .imm_err(imm_err), .err_cnt(err_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .ERRCNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready64), .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .ImmExt(ImmExt64),
        .out_tag(out_tag64), .imm_err(imm_err64), .err_cnt(err_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [7:0] tg);
        in_valid = v;
        instr    = ins;
        ImmSrc   = src;
        in_tag   = tg;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        step(); step();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_immext",    {32'd0, ImmExt},    64'd0);
        chk("rst_tag",       {56'd0, out_tag},   64'd0);
        chk("rst_err",       {63'd0, imm_err},   64'd0);
        chk("rst_errcnt",    {56'd0, err_cnt},   64'd0);
        rst = 1'b0;

        // I, then back-to-back S and B with streaming consumer
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'b000, 8'h01);
        step();
        chk("i_valid", {63'd0, out_valid}, 64'd1);
        chk("i_imm",   {32'd0, ImmExt},    64'hFFFFFFFF);
        chk("i_imm64", ImmExt64,           64'hFFFFFFFFFFFFFFFF);
        chk("i_tag",   {56'd0, out_tag},   64'h01);
        drive(1'b1, 32'hFE20AE23, 3'b001, 8'h02);
        step();
        chk("s_imm", {32'd0, ImmExt},  64'hFFFFFFFC);
        chk("s_tag", {56'd0, out_tag}, 64'h02);
        drive(1'b1, 32'hFE000CE3, 3'b010, 8'h03);
        step();
        chk("b_imm", {32'd0, ImmExt},  64'hFFFFFFF8);
        chk("b_tag", {56'd0, out_tag}, 64'h03);

        // U, Z, SH on both widths
        drive(1'b1, 32'h800000B7, 3'b100, 8'h04);
        step();
        chk("u_imm64", ImmExt64,        64'hFFFFFFFF80000000);
        chk("u_imm32", {32'd0, ImmExt}, 64'h80000000);
        drive(1'b1, 32'h000F8000, 3'b101, 8'h05);
        step();
        chk("z_imm64", ImmExt64,        64'h1F);
        chk("z_imm32", {32'd0, ImmExt}, 64'h1F);
        drive(1'b1, 32'h03F00000, 3'b110, 8'h06);
        step();
        chk("sh_imm64", ImmExt64,        64'h3F);
        chk("sh_imm32", {32'd0, ImmExt}, 64'h1F);
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: three entries with consumer stalled
        out_ready = 1'b0;
        drive(1'b1, 32'h00100000, 3'b000, 8'h10);
        step();
        chk("bp1_ready", {63'd0, in_ready}, 64'd1);
        chk("bp1_tag",   {56'd0, out_tag},  64'h10);
        drive(1'b1, 32'h00200000, 3'b000, 8'h11);
        step();
        chk("bp2_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'h00300000, 3'b000, 8'h12);
        step();
        chk("bp3_ready", {63'd0, in_ready}, 64'd0);
        chk("bp3_tag",   {56'd0, out_tag},  64'h10);
        chk("bp3_imm",   {32'd0, ImmExt},   64'h1);
        out_ready = 1'b1;
        step();
        chk("rel1_tag",   {56'd0, out_tag},  64'h11);
        chk("rel1_imm",   {32'd0, ImmExt},   64'h2);
        chk("rel1_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("rel2_tag", {56'd0, out_tag}, 64'h12);
        chk("rel2_imm", {32'd0, ImmExt},  64'h3);
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        step();
        chk("rel3_valid", {63'd0, out_valid}, 64'd0);

        // Flush from FULL with input presented
        out_ready = 1'b0;
        drive(1'b1, 32'h00500000, 3'b000, 8'h20);
        step();
        drive(1'b1, 32'h00600000, 3'b000, 8'h21);
        step();
        chk("fl_full_ready", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00700000, 3'b000, 8'h22);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready},  64'd1);

        // Flush from ONE, discarding an accepted illegal entry that still counts
        drive(1'b1, 32'h00800000, 3'b000, 8'h23);
        step();
        chk("fl1_tag", {56'd0, out_tag}, 64'h23);
        flush = 1'b1;
        drive(1'b1, 32'hFFFFFFFF, 3'b111, 8'h24);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        chk("fl1_valid",  {63'd0, out_valid}, 64'd0);
        chk("fl1_errcnt", {56'd0, err_cnt},   64'd1);
        out_ready = 1'b1;
        step();
        chk("fl1_none", {63'd0, out_valid}, 64'd0);

        // Illegal select stream to saturate the counter
        drive(1'b1, 32'hFFFFFFFF, 3'b111, 8'h30);
        step();
        chk("ill_valid",  {63'd0, out_valid}, 64'd1);
        chk("ill_imm",    {32'd0, ImmExt},    64'd0);
        chk("ill_imm64",  ImmExt64,           64'd0);
        chk("ill_err",    {63'd0, imm_err},   64'd1);
        chk("ill_errcnt", {56'd0, err_cnt},   64'd2);
        for (int i = 0; i < 299; i++) step();
        chk("sat_errcnt", {56'd0, err_cnt},   64'd255);
        chk("sat_err",    {63'd0, imm_err},   64'd1);
        chk("sat_imm",    {32'd0, ImmExt},    64'd0);

        // Asynchronous reset in mid-stream
        rst = 1'b1;
        #1;
        chk("arst_valid",  {63'd0, out_valid}, 64'd0);
        chk("arst_imm",    {32'd0, ImmExt},    64'd0);
        chk("arst_tag",    {56'd0, out_tag},   64'd0);
        chk("arst_err",    {63'd0, imm_err},   64'd0);
        chk("arst_errcnt", {56'd0, err_cnt},   64'd0);
        chk("arst_ready",  {63'd0, in_ready},  64'd1);
        step(); step();
        chk("arst_hold_valid",  {63'd0, out_valid}, 64'd0);
        chk("arst_hold_errcnt", {56'd0, err_cnt},   64'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
